// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_pkg
// Brief    : Instruction field layout, opcode map and ALU control encodings
//            shared by the decode stage feeding regalu.
// Revision : 1.0
// ============================================================================
package decode_pkg;

    localparam int c_NREG  = 32;
    localparam int c_REG_W = 5;
    localparam int c_OP_W  = 6;

    localparam int c_OP_LSB = 26;
    localparam int c_RS_LSB = 21;
    localparam int c_RT_LSB = 16;
    localparam int c_RD_LSB = 11;

    localparam logic [c_OP_W-1:0] c_OP_XOR  = 6'h00;
    localparam logic [c_OP_W-1:0] c_OP_XNOR = 6'h01;
    localparam logic [c_OP_W-1:0] c_OP_ADD  = 6'h02;
    localparam logic [c_OP_W-1:0] c_OP_SUB  = 6'h03;
    localparam logic [c_OP_W-1:0] c_OP_OR   = 6'h04;
    localparam logic [c_OP_W-1:0] c_OP_NOR  = 6'h05;
    localparam logic [c_OP_W-1:0] c_OP_AND  = 6'h06;

    localparam logic [2:0] c_S_XOR  = 3'b000;
    localparam logic [2:0] c_S_XNOR = 3'b001;
    localparam logic [2:0] c_S_ADD  = 3'b010;
    localparam logic [2:0] c_S_SUB  = 3'b011;
    localparam logic [2:0] c_S_OR   = 3'b100;
    localparam logic [2:0] c_S_NOR  = 3'b101;
    localparam logic [2:0] c_S_AND  = 3'b110;

    // R0 select driven by bubbles and reset
    localparam logic [c_NREG-1:0] c_SEL_BUBBLE = 32'h1;

    typedef struct packed {
        logic [2:0] s;
        logic       cin;
        logic       wr;
    } alu_ctl_t;

    function automatic alu_ctl_t decode_op(input logic [c_OP_W-1:0] op);
        alu_ctl_t ctl;
        ctl = '{s: c_S_XOR, cin: 1'b0, wr: 1'b0};
        case (op)
            c_OP_XOR:  ctl = '{s: c_S_XOR,  cin: 1'b0, wr: 1'b1};
            c_OP_XNOR: ctl = '{s: c_S_XNOR, cin: 1'b0, wr: 1'b1};
            c_OP_ADD:  ctl = '{s: c_S_ADD,  cin: 1'b0, wr: 1'b1};
            c_OP_SUB:  ctl = '{s: c_S_SUB,  cin: 1'b1, wr: 1'b1};
            c_OP_OR:   ctl = '{s: c_S_OR,   cin: 1'b0, wr: 1'b1};
            c_OP_NOR:  ctl = '{s: c_S_NOR,  cin: 1'b0, wr: 1'b1};
            c_OP_AND:  ctl = '{s: c_S_AND,  cin: 1'b0, wr: 1'b1};
            default:   ctl = '{s: c_S_XOR,  cin: 1'b0, wr: 1'b0};
        endcase
        return ctl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_dec.sv
`default_nettype none
// ============================================================================
// Module   : onehot_dec
// Brief    : Register index to one-hot register select.
// Revision : 1.0
// ============================================================================
module onehot_dec
    import decode_pkg::*;
#(
    parameter int NREG = c_NREG
) (
    input  logic [c_REG_W-1:0] i_idx,
    output logic [NREG-1:0]    o_onehot
);

    for (genvar k = 0; k < NREG; k++) begin : g_bit
        assign o_onehot[k] = (i_idx == c_REG_W'(k));
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : Decode/issue stage for regalu: one-hot operand selects, ALU
//            control, delayed write-back select and a one-bubble RAW interlock.
// Revision : 1.0
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int NREG = c_NREG
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [31:0]     ibus,
    input  logic            ivalid,
    output logic            iready,
    output logic [NREG-1:0] Aselect,
    output logic [NREG-1:0] Bselect,
    output logic [NREG-1:0] Dselect,
    output logic [2:0]      S,
    output logic            Cin
);

    logic [c_OP_W-1:0]  w_op;
    logic [c_REG_W-1:0] w_rs;
    logic [c_REG_W-1:0] w_rt;
    logic [c_REG_W-1:0] w_rd;
    alu_ctl_t           w_ctl;
    logic [NREG-1:0]    w_rs_oh;
    logic [NREG-1:0]    w_rt_oh;
    logic [NREG-1:0]    w_erd_oh;
    logic               w_hazard;
    logic               w_xfer;
    logic               w_unused_bits;

    // E stage
    logic [NREG-1:0]    r_asel;
    logic [NREG-1:0]    r_bsel;
    logic [2:0]         r_s;
    logic               r_cin;
    logic               r_e_wv;
    logic [c_REG_W-1:0] r_e_rd;
    // W stage
    logic [NREG-1:0]    r_dsel;

    assign w_op  = ibus[c_OP_LSB +: c_OP_W];
    assign w_rs  = ibus[c_RS_LSB +: c_REG_W];
    assign w_rt  = ibus[c_RT_LSB +: c_REG_W];
    assign w_rd  = ibus[c_RD_LSB +: c_REG_W];
    assign w_ctl = decode_op(w_op);
    assign w_unused_bits = &{1'b0, ibus[c_RD_LSB-1:0]};

    onehot_dec #(.NREG(NREG)) u_rs_dec (.i_idx(w_rs),   .o_onehot(w_rs_oh));
    onehot_dec #(.NREG(NREG)) u_rt_dec (.i_idx(w_rt),   .o_onehot(w_rt_oh));
    onehot_dec #(.NREG(NREG)) u_rd_dec (.i_idx(r_e_rd), .o_onehot(w_erd_oh));

    // regalu has no forwarding: hold a reader of the in-flight destination
    // for one cycle, by which time that write has reached the W stage.
    assign w_hazard = ivalid && r_e_wv && (r_e_rd != '0)
                      && ((w_rs == r_e_rd) || (w_rt == r_e_rd));
    assign iready   = !w_hazard;
    assign w_xfer   = ivalid && iready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_asel <= NREG'(c_SEL_BUBBLE);
            r_bsel <= NREG'(c_SEL_BUBBLE);
            r_s    <= c_S_XOR;
            r_cin  <= 1'b0;
            r_e_wv <= 1'b0;
            r_e_rd <= '0;
            r_dsel <= '0;
        end else begin
            r_dsel <= r_e_wv ? w_erd_oh : '0;
            if (w_xfer) begin
                r_asel <= w_rs_oh;
                r_bsel <= w_rt_oh;
                r_s    <= w_ctl.s;
                r_cin  <= w_ctl.cin;
                r_e_wv <= w_ctl.wr && (w_rd != '0);
                r_e_rd <= w_rd;
            end else begin
                r_asel <= NREG'(c_SEL_BUBBLE);
                r_bsel <= NREG'(c_SEL_BUBBLE);
                r_s    <= c_S_XOR;
                r_cin  <= 1'b0;
                r_e_wv <= 1'b0;
                r_e_rd <= '0;
            end
        end
    end

    assign Aselect = r_asel;
    assign Bselect = r_bsel;
    assign S       = r_s;
    assign Cin     = r_cin;
    assign Dselect = r_dsel;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Self-checking bench for decode_stage against a cycle-schedule
//            reference model. Revision : 1.0
// ============================================================================
module tb_decode_stage;

    localparam int c_MAXC = 4096;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] ibus = '0;
    logic        ivalid = 1'b0;
    logic        iready;
    logic [31:0] Aselect;
    logic [31:0] Bselect;
    logic [31:0] Dselect;
    logic [2:0]  S;
    logic        Cin;

    always #5 clk = ~clk;

    decode_stage #(.NREG(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ibus    (ibus),
        .ivalid  (ivalid),
        .iready  (iready),
        .Aselect (Aselect),
        .Bselect (Bselect),
        .Dselect (Dselect),
        .S       (S),
        .Cin     (Cin)
    );

    // Expected outputs indexed by cycle (cycle k = interval after rising edge k)
    logic [31:0] exp_a [c_MAXC];
    logic [31:0] exp_b [c_MAXC];
    logic [31:0] exp_d [c_MAXC];
    logic [2:0]  exp_s [c_MAXC];
    logic        exp_c [c_MAXC];

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        prev_wr = 1'b0;
    logic [4:0]  prev_rd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // {writes, S, Cin} straight from the opcode table
    function automatic logic [4:0] ref_ctl(input logic [5:0] op);
        case (op)
            6'h00:   return 5'b1_000_0;
            6'h01:   return 5'b1_001_0;
            6'h02:   return 5'b1_010_0;
            6'h03:   return 5'b1_011_1;
            6'h04:   return 5'b1_100_0;
            6'h05:   return 5'b1_101_0;
            6'h06:   return 5'b1_110_0;
            default: return 5'b0_000_0;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, rd, 11'h000};
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, input logic rst, output logic acc);
        logic [4:0] rs, rt, rd;
        logic [4:0] ctl;
        logic       stall;
        logic       wr;
        @(negedge clk);
        if (cyc + 2 >= c_MAXC) begin
            $display("FAIL cycle_budget (cycle %0d): got %0d expected < %0d", cyc, cyc, c_MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        if (cyc > 0) begin
            chk("aselect", Aselect, exp_a[cyc]);
            chk("bselect", Bselect, exp_b[cyc]);
            chk("dselect", Dselect, exp_d[cyc]);
            chk("s", {29'b0, S}, {29'b0, exp_s[cyc]});
            chk("cin", {31'b0, Cin}, {31'b0, exp_c[cyc]});
        end
        reset_n = !rst;
        ivalid  = v;
        ibus    = ins;
        #1;
        rs  = ins[25:21];
        rt  = ins[20:16];
        rd  = ins[15:11];
        ctl = ref_ctl(ins[31:26]);
        stall = v && prev_wr && (rs == prev_rd || rt == prev_rd);
        if (cyc > 0)
            chk("iready", {31'b0, iready}, {31'b0, !stall});
        acc = !rst && v && !stall;
        if (rst) begin
            exp_a[cyc+1] = 32'h1;
            exp_b[cyc+1] = 32'h1;
            exp_s[cyc+1] = 3'b000;
            exp_c[cyc+1] = 1'b0;
            exp_d[cyc+1] = '0;
            exp_d[cyc+2] = '0;
            prev_wr = 1'b0;
        end else if (acc) begin
            wr = ctl[4] && (rd != 5'd0);
            exp_a[cyc+1] = 32'h1 << rs;
            exp_b[cyc+1] = 32'h1 << rt;
            exp_s[cyc+1] = ctl[3:1];
            exp_c[cyc+1] = ctl[0];
            exp_d[cyc+2] = wr ? (32'h1 << rd) : 32'h0;
            prev_wr = wr;
            prev_rd = rd;
        end else begin
            prev_wr = 1'b0;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic issue(input logic [31:0] ins, output int tries);
        logic acc;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 4) begin
            step(1'b1, ins, 1'b0, acc);
            tries++;
        end
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout (cycle %0d): got not accepted expected accepted", cyc);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, acc);
    endtask

    initial begin
        int          tries;
        logic        acc;
        logic        have_pend;
        logic [31:0] pend;
        logic        v, rst;
        logic [5:0]  op;
        logic [31:0] ins;

        for (int i = 0; i < c_MAXC; i++) begin
            exp_a[i] = 32'h1;
            exp_b[i] = 32'h1;
            exp_d[i] = 32'h0;
            exp_s[i] = 3'b000;
            exp_c[i] = 1'b0;
        end

        // reset held two cycles with a valid instruction presented
        step(1'b1, mk(6'h02, 5'd3, 5'd1, 5'd2), 1'b1, acc);
        step(1'b1, mk(6'h02, 5'd3, 5'd1, 5'd2), 1'b1, acc);

        issue(mk(6'h02, 5'd3, 5'd1, 5'd2), tries);
        chk("add_tries", tries, 1);
        idle(2);

        // RAW: SUB r4,r3,r1 then OR r5,r4,r0
        issue(mk(6'h03, 5'd4, 5'd3, 5'd1), tries);
        chk("sub_tries", tries, 1);
        issue(mk(6'h04, 5'd5, 5'd4, 5'd0), tries);
        chk("raw_tries", tries, 2);
        idle(2);

        // rd=0 never writes; illegal opcode neither writes nor stalls
        issue(mk(6'h00, 5'd0, 5'd5, 5'd6), tries);
        issue(mk(6'h3F, 5'd7, 5'd0, 5'd6), tries);
        chk("illegal_tries", tries, 1);
        issue(mk(6'h02, 5'd9, 5'd7, 5'd7), tries);
        chk("after_illegal_tries", tries, 1);
        idle(2);

        // independent stream covering every opcode
        for (int i = 0; i < 7; i++) begin
            issue(mk(6'(i), 5'(10 + i), 5'(i + 1), 5'(20 + i)), tries);
            chk("stream_tries", tries, 1);
        end
        idle(2);

        // reset while a write is pending in W
        issue(mk(6'h02, 5'd3, 5'd1, 5'd2), tries);
        idle(1);
        step(1'b0, 32'h0, 1'b1, acc);
        idle(2);

        // randomized traffic over a small register set to provoke hazards
        have_pend = 1'b0;
        pend      = '0;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (have_pend) begin
                v   = 1'b1;
                ins = pend;
            end else begin
                v  = ($urandom_range(0, 4) != 0);
                op = ($urandom_range(0, 9) < 8) ? 6'($urandom_range(0, 6))
                                                : 6'($urandom_range(7, 63));
                ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 11'($urandom)};
            end
            step(v, ins, rst, acc);
            have_pend = v && !acc && !rst;
            pend      = ins;
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
